// File: rtl/eth_fifo_pkg.sv
// ---------------------------------------------------------------------------
// eth_fifo_pkg
//   Shared definitions for the Ethernet prefetch FIFO write side.
//   - c_BYTES / c_BW      : bytes per FIFO word and width of the byte-count field
//   - TAG_NB/TAG_LAST/TAG_ERR : bit positions of the side tag in a FIFO word
//   - c_WR_DATA_WIDTH     : full FIFO word width {err, last, nbytes-1, data}
//   - fsm_state_t         : packer FSM encoding
// ---------------------------------------------------------------------------
package eth_fifo_pkg;

    localparam int c_BYTES = 4;
    localparam int c_BW    = $clog2(c_BYTES);

    // Word layout, LSB first: data bytes, nbytes-1, last, err.
    localparam int TAG_NB   = 8 * c_BYTES;
    localparam int TAG_LAST = TAG_NB + c_BW;
    localparam int TAG_ERR  = TAG_LAST + 1;

    function automatic int wr_data_width(input int bytes);
        return 8 * bytes + $clog2(bytes) + 2;
    endfunction

    localparam int c_WR_DATA_WIDTH = wr_data_width(c_BYTES);

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/eth_fifo_word_hold.sv
// ---------------------------------------------------------------------------
// eth_fifo_word_hold
//   One-entry holding register between the packer and the FIFO write port.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     load          capture load_data this cycle (only issued when in_ready)
//     load_data     word to capture
//     out_ready     downstream can take a word (FIFO not full)
//     in_ready      register can take a word this cycle
//     hold_vld      register occupied
//     hold_data     stored word (cleared by reset only)
//     push          word leaves the register this cycle
//   Handshake: a word leaves when hold_vld & out_ready; a new word may be
//   loaded in that same cycle, so one word per cycle can flow through.
// ---------------------------------------------------------------------------
module eth_fifo_word_hold
    import eth_fifo_pkg::*;
#(
    parameter int W = c_WR_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         in_ready,
    output logic         hold_vld,
    output logic [W-1:0] hold_data,
    output logic         push
);

    assign push     = hold_vld & out_ready;
    assign in_ready = ~hold_vld | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else if (load) begin
            hold_vld  <= 1'b1;
            hold_data <= load_data;
        end else if (push) begin
            hold_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/eth_fifo_word_packer.sv
// ---------------------------------------------------------------------------
// eth_fifo_word_packer
//   Packs an 8-bit byte stream little-endian into c_BYTES-wide FIFO words
//   with a side tag {err, last, nbytes-1} and pushes them into the FIFO.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     s_data/s_valid/s_last/s_err/s_ready   byte stream input
//     fifo_wr_data    {err, last, nbytes-1, data}
//     fifo_wr_en      FIFO write strobe
//     fifo_wr_vld     FIFO not full
//     frame_cnt       frames whose last word was pushed (saturating)
//     err_cnt         frames whose last word carried err=1 (saturating)
//     busy            mid-frame or holding register occupied
//     fsm_state       packer FSM state (0 = IDLE, 1 = IN_FRAME)
//   Handshake: a byte transfers on a rising edge where s_valid & s_ready;
//   s_valid with s_ready low has no effect. s_err only matters with s_last.
// ---------------------------------------------------------------------------
module eth_fifo_word_packer
    import eth_fifo_pkg::*;
#(
    parameter int c_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 s_data,
    input  logic                       s_valid,
    input  logic                       s_last,
    input  logic                       s_err,
    output logic                       s_ready,
    output logic [c_WR_DATA_WIDTH-1:0] fifo_wr_data,
    output logic                       fifo_wr_en,
    input  logic                       fifo_wr_vld,
    output logic [c_CNT_WIDTH-1:0]     frame_cnt,
    output logic [c_CNT_WIDTH-1:0]     err_cnt,
    output logic                       busy,
    output logic                       fsm_state
);

    localparam logic [c_CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [c_BW-1:0]        IDX_LAST = c_BW'(c_BYTES - 1);

    fsm_state_t                 state;
    logic                       run;
    logic [c_BW-1:0]            idx;
    logic [8*c_BYTES-1:0]       acc_data;
    logic [8*c_BYTES-1:0]       word_data;
    logic [c_WR_DATA_WIDTH-1:0] word;
    logic                       accept;
    logic                       complete;
    logic                       hold_in_ready;
    logic                       hold_vld;
    logic                       push;

    // Keeps s_ready low while reset is asserted; rises one clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign s_ready  = run & hold_in_ready;
    assign accept   = s_valid & s_ready;
    assign complete = accept & (s_last | (idx == IDX_LAST));

    // Completed word: bytes already collected, the current byte at idx,
    // and zeros above it for a short final word.
    always_comb begin
        word_data = '0;
        for (int k = 0; k < c_BYTES; k++) begin
            if (c_BW'(k) < idx) begin
                word_data[8*k +: 8] = acc_data[8*k +: 8];
            end else if (c_BW'(k) == idx) begin
                word_data[8*k +: 8] = s_data;
            end
        end
    end

    assign word = {s_err & s_last, s_last, idx, word_data};

    // Accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            acc_data <= '0;
        end else if (complete) begin
            idx      <= '0;
        end else if (accept) begin
            acc_data[8*idx +: 8] <= s_data;
            idx                  <= idx + 1'b1;
        end
    end

    eth_fifo_word_hold #(
        .W(c_WR_DATA_WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (complete),
        .load_data(word),
        .out_ready(fifo_wr_vld),
        .in_ready (hold_in_ready),
        .hold_vld (hold_vld),
        .hold_data(fifo_wr_data),
        .push     (push)
    );

    assign fifo_wr_en = push;

    // Frame FSM: a single-byte frame never leaves IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (accept && !s_last) state <= IN_FRAME;
                IN_FRAME: if (accept && s_last)  state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign fsm_state = (state == IN_FRAME);
    assign busy      = (state == IN_FRAME) | hold_vld;

    // Statistics, counted when the frame's last word actually enters the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (push && fifo_wr_data[TAG_LAST]) begin
            if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + 1'b1;
            if (fifo_wr_data[TAG_ERR] && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_eth_fifo_word_packer.sv
module tb_eth_fifo_word_packer;

    localparam int CW   = 4;
    localparam int W    = 36;
    localparam int CMAX = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_err = 1'b0;
    logic          s_ready;
    logic [W-1:0]  fifo_wr_data;
    logic          fifo_wr_en;
    logic          fifo_wr_vld = 1'b1;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] err_cnt;
    logic          busy;
    logic          fsm_state;

    eth_fifo_word_packer #(
        .c_CNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_err       (s_err),
        .s_ready     (s_ready),
        .fifo_wr_data(fifo_wr_data),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_vld (fifo_wr_vld),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [7:0]   frame_q[$];
    int           mdl_frames = 0;
    int           mdl_errs = 0;
    int           stalls = 0;
    int           ready_low = 0;
    logic         in_frame_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            mdl_frames = 0;
            mdl_errs   = 0;
            check("rst_s_ready", 64'(s_ready), 64'd0);
            check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
            check("rst_wr_data", 64'(fifo_wr_data), 64'd0);
            check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
            check("rst_err_cnt", 64'(err_cnt), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_fsm", 64'(fsm_state), 64'd0);
        end else begin
            check("frame_cnt", 64'(frame_cnt), 64'(mdl_frames));
            check("err_cnt", 64'(err_cnt), 64'(mdl_errs));
            if (fifo_wr_en !== 1'b0) begin
                got_q.push_back(fifo_wr_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(fifo_wr_data), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_data", 64'(fifo_wr_data), 64'(e));
                    if (e[34] && mdl_frames < CMAX) mdl_frames++;
                    if (e[34] && e[35] && mdl_errs < CMAX) mdl_errs++;
                end
            end
        end
    end

    always @(negedge clk) if (fsm_state === 1'b1) in_frame_seen = 1'b1;

    // ---------------- driver tasks ----------------
    // Expected words of the frame in frame_q: groups of 4 bytes little-endian,
    // tag carries byte count minus one; last/err only on the final word.
    task automatic model_frame(input logic err);
        int n, nw, nb;
        logic [31:0] d;
        logic lst;
        n  = frame_q.size();
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            nb = n - 4 * w;
            if (nb > 4) nb = 4;
            d = '0;
            for (int k = 0; k < nb; k++) d = d | (32'(frame_q[4*w+k]) << (8 * k));
            lst = (w == nw - 1);
            exp_q.push_back({lst & err, lst, 2'(nb - 1), d});
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic lst, input logic er);
        int   waits;
        logic ok;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = lst;
        s_err   = er;
        waits   = 0;
        do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            waits++;
        end while (!ok && waits < 200);
        stalls += waits - 1;
        if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    // noise drives s_err on non-last bytes, which must be ignored
    task automatic send_frame(input logic err, input logic noise, input logic with_model);
        int n;
        n = frame_q.size();
        stalls = 0;
        if (with_model) model_frame(err);
        for (int i = 0; i < n; i++) begin
            send_byte(frame_q[i], (i == n - 1) && with_model, (i == n - 1) ? err : noise);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_err   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [7:0] first, input logic [7:0] step);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(first + 8'(i) * step);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 8-byte frame 01..08
        got_q.delete();
        fill(8, 8'h01, 8'h01);
        send_frame(1'b0, 1'b0, 1'b1);
        drain();
        check("t1_nwords", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            check("t1_word0", 64'(got_q[0]), 64'h3_0403_0201);
            check("t1_word1", 64'(got_q[1]), 64'h7_0807_0605);
        end
        check("t1_frame_cnt", 64'(frame_cnt), 64'd1);

        // 5-byte frame AA..EE, error on last byte
        got_q.delete();
        fill(5, 8'hAA, 8'h11);
        send_frame(1'b1, 1'b0, 1'b1);
        drain();
        check("t2_nwords", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            check("t2_word0", 64'(got_q[0]), 64'h3_DDCC_BBAA);
            check("t2_word1", 64'(got_q[1]), 64'hC_0000_00EE);
        end
        check("t2_err_cnt", 64'(err_cnt), 64'd1);
        check("t2_frame_cnt", 64'(frame_cnt), 64'd2);

        // single-byte frame
        got_q.delete();
        in_frame_seen = 1'b0;
        fill(1, 8'h5A, 8'h00);
        send_frame(1'b0, 1'b0, 1'b1);
        drain();
        check("t3_fsm_stayed_idle", 64'(in_frame_seen), 64'd0);
        check("t3_nwords", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) check("t3_word0", 64'(got_q[0]), 64'h4_0000_005A);

        // 12-byte frame with the FIFO full for 10 clocks mid-frame
        got_q.delete();
        ready_low = 0;
        fill(12, 8'h30, 8'h01);
        fork
            send_frame(1'b0, 1'b0, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #2 fifo_wr_vld = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    check("t4_no_write_when_full", 64'(fifo_wr_en), 64'd0);
                    if (s_ready === 1'b0) ready_low++;
                end
                @(posedge clk);
                #2 fifo_wr_vld = 1'b1;
            end
        join
        drain();
        check("t4_ready_dropped", 64'(ready_low > 0), 64'd1);
        check("t4_nwords", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) check("t4_word2", 64'(got_q[2]), 64'h7_3B3A_3938);
        check("t4_frame_cnt", 64'(frame_cnt), 64'd4);

        // 6-byte frame with s_err toggling on non-last bytes only
        got_q.delete();
        fill(6, 8'h40, 8'h01);
        send_frame(1'b0, 1'b1, 1'b1);
        drain();
        check("t5_nwords", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) check("t5_word1", 64'(got_q[1]), 64'h5_0000_4544);
        check("t5_err_cnt", 64'(err_cnt), 64'd1);

        // back-to-back 12 bytes with FIFO always ready: no stall cycles
        fill(12, 8'h50, 8'h01);
        send_frame(1'b0, 1'b0, 1'b1);
        check("t6_stalls", 64'(stalls), 64'd0);
        drain();
        check("t6_frame_cnt", 64'(frame_cnt), 64'd6);

        // reset after 3 bytes of a frame
        fill(3, 8'h21, 8'h01);
        send_frame(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t7_busy_mid_frame", 64'(busy), 64'd1);
        check("t7_in_frame", 64'(fsm_state), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // next frame after reset
        got_q.delete();
        fill(4, 8'h11, 8'h01);
        send_frame(1'b0, 1'b0, 1'b1);
        drain();
        check("t8_nwords", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) check("t8_word0", 64'(got_q[0]), 64'h7_1413_1211);
        check("t8_frame_cnt", 64'(frame_cnt), 64'd1);

        // 17 more errored frames: both counters must stop at 0xF
        for (int f = 0; f < 17; f++) begin
            fill((f % 6) + 1, 8'(16 * f), 8'h01);
            send_frame(1'b1, 1'b0, 1'b1);
        end
        drain();
        check("t9_frame_cnt_sat", 64'(frame_cnt), 64'hF);
        check("t9_err_cnt_sat", 64'(err_cnt), 64'hF);
        check("t9_busy_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
